// File: rtl/alu_pkg.sv
// Shared definitions for the UART/ALU frame path: opcodes, sequencer states
// and the opcode acceptance check.
package alu_pkg;

    localparam logic [5:0] OP_ADD = 6'b100000;
    localparam logic [5:0] OP_SUB = 6'b100010;
    localparam logic [5:0] OP_AND = 6'b100100;
    localparam logic [5:0] OP_OR  = 6'b100101;
    localparam logic [5:0] OP_XOR = 6'b100110;
    localparam logic [5:0] OP_NOR = 6'b100111;
    localparam logic [5:0] OP_SRA = 6'b000011;
    localparam logic [5:0] OP_SRL = 6'b000010;

    typedef enum logic [2:0] {
        WAIT_A,
        WAIT_B,
        WAIT_OP,
        EXEC,
        SEND,
        WAIT_TX
    } state_t;

    // The two spare bits of the opcode byte must be zero.
    function automatic logic op_is_valid(input logic [7:0] op_byte);
        if (op_byte[7:6] != 2'b00) begin
            return 1'b0;
        end
        case (op_byte[5:0])
            OP_ADD, OP_SUB, OP_AND, OP_OR,
            OP_XOR, OP_NOR, OP_SRA, OP_SRL: return 1'b1;
            default:                        return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/frame_timeout_counter.sv
// Counts idle cycles inside a partially received frame and flags expiry
// once TIMEOUT_CYCLES idle cycles have elapsed (0 disables the check).
module frame_timeout_counter #(
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] count;

    // Saturates at LIMIT so a stalled enable can never wrap back to zero.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n || i_clear) begin
            count <= '0;
        end else if (i_enable && (count != LIMIT)) begin
            count <= count + CNT_W'(1);
        end
    end

    assign o_expired = (TIMEOUT_CYCLES != 0) && i_enable && (count == LIMIT);

endmodule

// File: rtl/uart_alu_interface.sv
// Frame sequencer: collects A, B and opcode bytes from the UART, drives the
// ALU, and returns the result to the UART transmitter.
module uart_alu_interface
    import alu_pkg::*;
#(
    parameter int NB_DATA        = 8,
    parameter int NB_OP          = 6,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic [NB_DATA-1:0] i_rx_data,
    input  logic               i_rx_done,
    output logic [NB_DATA-1:0] o_alu_a,
    output logic [NB_DATA-1:0] o_alu_b,
    output logic [NB_OP-1:0]   o_alu_op,
    input  logic [NB_DATA-1:0] i_alu_res,
    output logic [NB_DATA-1:0] o_tx_data,
    output logic               o_tx_start,
    input  logic               i_tx_done,
    output logic               o_op_err,
    output logic               o_rx_drop,
    output logic               o_timeout
);

    state_t state;
    logic   in_frame;
    logic   expired;

    assign in_frame = (state == WAIT_B) || (state == WAIT_OP);

    frame_timeout_counter #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_clear  (!in_frame || i_rx_done),
        .i_enable (in_frame),
        .o_expired(expired)
    );

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state      <= WAIT_A;
            o_alu_a    <= '0;
            o_alu_b    <= '0;
            o_alu_op   <= '0;
            o_tx_data  <= '0;
            o_tx_start <= 1'b0;
            o_op_err   <= 1'b0;
            o_rx_drop  <= 1'b0;
            o_timeout  <= 1'b0;
        end else begin
            o_tx_start <= 1'b0;
            o_op_err   <= 1'b0;
            o_rx_drop  <= 1'b0;
            o_timeout  <= 1'b0;
            case (state)
                WAIT_A: begin
                    if (i_rx_done) begin
                        o_alu_a <= i_rx_data;
                        state   <= WAIT_B;
                    end
                end
                WAIT_B: begin
                    if (i_rx_done) begin
                        o_alu_b <= i_rx_data;
                        state   <= WAIT_OP;
                    end else if (expired) begin
                        o_timeout <= 1'b1;
                        state     <= WAIT_A;
                    end
                end
                WAIT_OP: begin
                    if (i_rx_done) begin
                        if (op_is_valid(i_rx_data[7:0])) begin
                            o_alu_op <= i_rx_data[NB_OP-1:0];
                            state    <= EXEC;
                        end else begin
                            o_op_err <= 1'b1;
                            state    <= WAIT_A;
                        end
                    end else if (expired) begin
                        o_timeout <= 1'b1;
                        state     <= WAIT_A;
                    end
                end
                // The ALU has had this whole cycle to settle on the new opcode.
                EXEC: begin
                    o_tx_data  <= i_alu_res;
                    o_tx_start <= 1'b1;
                    o_rx_drop  <= i_rx_done;
                    state      <= SEND;
                end
                SEND: begin
                    o_rx_drop <= i_rx_done;
                    state     <= WAIT_TX;
                end
                // A coincident byte is dropped but does not block the tx handshake.
                WAIT_TX: begin
                    o_rx_drop <= i_rx_done;
                    if (i_tx_done) begin
                        state <= WAIT_A;
                    end
                end
                default: state <= WAIT_A;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_alu_interface.sv
// Directed bench for uart_alu_interface with a behavioural reference ALU.
module tb_uart_alu_interface;
    import alu_pkg::*;

    localparam int NB_DATA = 8;
    localparam int NB_OP   = 6;
    localparam int TO      = 16;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic [NB_DATA-1:0] rx_data = '0;
    logic               rx_done = 1'b0;
    logic [NB_DATA-1:0] alu_a, alu_b, alu_res, tx_data;
    logic [NB_OP-1:0]   alu_op;
    logic               tx_start, op_err, rx_drop, timeout;
    logic               tx_done = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    uart_alu_interface #(
        .NB_DATA(NB_DATA),
        .NB_OP(NB_OP),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .i_clk(clk),
        .i_rst_n(rst_n),
        .i_rx_data(rx_data),
        .i_rx_done(rx_done),
        .o_alu_a(alu_a),
        .o_alu_b(alu_b),
        .o_alu_op(alu_op),
        .i_alu_res(alu_res),
        .o_tx_data(tx_data),
        .o_tx_start(tx_start),
        .i_tx_done(tx_done),
        .o_op_err(op_err),
        .o_rx_drop(rx_drop),
        .o_timeout(timeout)
    );

    always_comb begin
        alu_res = '0;
        case (alu_op)
            OP_ADD: alu_res = alu_a + alu_b;
            OP_SUB: alu_res = alu_a - alu_b;
            OP_AND: alu_res = alu_a & alu_b;
            OP_OR:  alu_res = alu_a | alu_b;
            OP_XOR: alu_res = alu_a ^ alu_b;
            OP_NOR: alu_res = ~(alu_a | alu_b);
            OP_SRA: alu_res = 8'($signed(alu_a) >>> alu_b);
            OP_SRL: alu_res = alu_a >> alu_b;
            default: alu_res = '0;
        endcase
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Byte is presented for exactly one cycle; returns one cycle after it.
    task automatic send_byte(input logic [7:0] b);
        tick();
        rx_data = b;
        rx_done = 1'b1;
        tick();
        rx_done = 1'b0;
    endtask

    task automatic finish_tx();
        tick();
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        checks++;
        if ({alu_a, alu_b, alu_op, tx_data, tx_start, op_err, rx_drop, timeout} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got a=%h b=%h op=%b tx=%h st=%b err=%b drop=%b to=%b, expected all 0",
                     alu_a, alu_b, alu_op, tx_data, tx_start, op_err, rx_drop, timeout);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_add();
        send_byte(8'h06);
        send_byte(8'h01);
        send_byte(8'h20);
        checks++;
        if (alu_a !== 8'h06 || alu_b !== 8'h01 || alu_op !== 6'b100000) begin
            errors++;
            $display("FAIL add_operands: got a=%h b=%h op=%b, expected a=06 b=01 op=100000", alu_a, alu_b, alu_op);
        end
        checks++;
        if (tx_start !== 1'b0) begin
            errors++;
            $display("FAIL add_start_early: got tx_start=%b in EXEC, expected 0", tx_start);
        end
        tick();
        checks++;
        if (tx_start !== 1'b1 || tx_data !== 8'h07) begin
            errors++;
            $display("FAIL add_result: got tx_start=%b tx_data=%h, expected 1 and 07", tx_start, tx_data);
        end
        tick();
        checks++;
        if (tx_start !== 1'b0) begin
            errors++;
            $display("FAIL add_single_start: got tx_start=%b, expected 0", tx_start);
        end
        finish_tx();
    endtask

    task automatic test_sub_hold();
        int bad;
        send_byte(8'h30);
        send_byte(8'h96);
        send_byte(8'h22);
        tick();
        checks++;
        if (tx_start !== 1'b1 || tx_data !== 8'h9A) begin
            errors++;
            $display("FAIL sub_result: got tx_start=%b tx_data=%h, expected 1 and 9a", tx_start, tx_data);
        end
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (tx_start !== 1'b0 || tx_data !== 8'h9A) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL sub_hold: got %0d cycles with restart or changed data, expected 0", bad);
        end
        finish_tx();
    endtask

    task automatic test_invalid_op();
        int starts;
        send_byte(8'h0F);
        send_byte(8'h05);
        send_byte(8'h3F);
        checks++;
        if (op_err !== 1'b1 || alu_op !== 6'b100010) begin
            errors++;
            $display("FAIL bad_op_err: got op_err=%b alu_op=%b, expected 1 and 100010", op_err, alu_op);
        end
        starts = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (tx_start !== 1'b0) starts++;
        end
        checks++;
        if (starts != 0 || op_err !== 1'b0) begin
            errors++;
            $display("FAIL bad_op_quiet: got %0d starts op_err=%b, expected 0 and 0", starts, op_err);
        end
        send_byte(8'h8F);
        send_byte(8'hAA);
        send_byte(8'h24);
        tick();
        checks++;
        if (tx_start !== 1'b1 || tx_data !== 8'h8A) begin
            errors++;
            $display("FAIL recover_and: got tx_start=%b tx_data=%h, expected 1 and 8a", tx_start, tx_data);
        end
        finish_tx();
    endtask

    task automatic test_busy_drop();
        send_byte(8'h10);
        send_byte(8'h03);
        send_byte(8'h26);
        tick();
        tick();
        rx_data = 8'hEE;
        rx_done = 1'b1;
        tick();
        rx_done = 1'b0;
        checks++;
        if (rx_drop !== 1'b1 || tx_data !== 8'h13) begin
            errors++;
            $display("FAIL busy_drop: got rx_drop=%b tx_data=%h, expected 1 and 13", rx_drop, tx_data);
        end
        tick();
        checks++;
        if (rx_drop !== 1'b0 || tx_start !== 1'b0) begin
            errors++;
            $display("FAIL busy_drop_pulse: got rx_drop=%b tx_start=%b, expected 0 and 0", rx_drop, tx_start);
        end
        rx_done = 1'b1;
        tx_done = 1'b1;
        tick();
        rx_done = 1'b0;
        tx_done = 1'b0;
        checks++;
        if (rx_drop !== 1'b1 || alu_a !== 8'h10) begin
            errors++;
            $display("FAIL busy_coincident: got rx_drop=%b alu_a=%h, expected 1 and 10", rx_drop, alu_a);
        end
        send_byte(8'h0F);
        send_byte(8'h05);
        send_byte(8'h22);
        tick();
        checks++;
        if (tx_start !== 1'b1 || tx_data !== 8'h0A) begin
            errors++;
            $display("FAIL busy_next_frame: got tx_start=%b tx_data=%h, expected 1 and 0a", tx_start, tx_data);
        end
        finish_tx();
    endtask

    task automatic test_timeout();
        send_byte(8'h05);
        repeat (TO) tick();
        checks++;
        if (timeout !== 1'b0) begin
            errors++;
            $display("FAIL timeout_early: got timeout=%b in expiry cycle, expected 0", timeout);
        end
        tick();
        checks++;
        if (timeout !== 1'b1 || alu_a !== 8'h05) begin
            errors++;
            $display("FAIL timeout_pulse: got timeout=%b alu_a=%h, expected 1 and 05", timeout, alu_a);
        end
        tick();
        checks++;
        if (timeout !== 1'b0) begin
            errors++;
            $display("FAIL timeout_width: got timeout=%b, expected 0", timeout);
        end
        send_byte(8'h03);
        checks++;
        if (alu_a !== 8'h03 || alu_b !== 8'h05) begin
            errors++;
            $display("FAIL timeout_back_to_a: got alu_a=%h alu_b=%h, expected 03 and 05", alu_a, alu_b);
        end
        repeat (TO - 1) tick();
        send_byte(8'h04);
        checks++;
        if (timeout !== 1'b0 || alu_b !== 8'h04) begin
            errors++;
            $display("FAIL expiry_byte_wins: got timeout=%b alu_b=%h, expected 0 and 04", timeout, alu_b);
        end
        send_byte(8'h20);
        tick();
        checks++;
        if (tx_start !== 1'b1 || tx_data !== 8'h07) begin
            errors++;
            $display("FAIL expiry_frame: got tx_start=%b tx_data=%h, expected 1 and 07", tx_start, tx_data);
        end
        finish_tx();
    endtask

    task automatic test_reset_mid_frame();
        int starts;
        send_byte(8'h11);
        send_byte(8'h22);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checks++;
        if ({alu_a, alu_b, alu_op, tx_data, tx_start, op_err, rx_drop, timeout} !== '0) begin
            errors++;
            $display("FAIL reset_mid_outputs: got a=%h b=%h op=%b tx=%h st=%b err=%b drop=%b to=%b, expected all 0",
                     alu_a, alu_b, alu_op, tx_data, tx_start, op_err, rx_drop, timeout);
        end
        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'h20);
        tick();
        checks++;
        if (tx_start !== 1'b1 || tx_data !== 8'h01) begin
            errors++;
            $display("FAIL reset_next_frame: got tx_start=%b tx_data=%h, expected 1 and 01", tx_start, tx_data);
        end
        starts = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (tx_start !== 1'b0) starts++;
        end
        checks++;
        if (starts != 0) begin
            errors++;
            $display("FAIL reset_frame_single_start: got %0d extra starts, expected 0", starts);
        end
        finish_tx();
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub_hold();
        test_invalid_op();
        test_busy_drop();
        test_timeout();
        test_reset_mid_frame();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
